// File: rtl/assoc_dcache.sv
// assoc_dcache: set-associative, write-back, write-allocate data cache with true-LRU
// replacement and a halt-triggered flush that writes back every dirty line, then
// stores the hit count to HITCNT_ADDR.
//
// Ports:
//   CLK, nRST           clock (rising edge), asynchronous active-low reset
//   halt                requests a flush (sampled only when idle)
//   dmemREN, dmemWEN    datapath read / write request (both high = write)
//   dmemaddr, dmemstore datapath word-aligned byte address and write data
//   dmemload, dhit      read data and request-complete strobe
//   flushed             flush complete, held until reset
//   memREN, memWEN      RAM read / write request (never both high)
//   memaddr, memstore   RAM byte address and write data
//   memload, dwait      RAM read data and busy flag
module assoc_dcache #(
    parameter int unsigned NSETS       = 8,
    parameter int unsigned NWAYS       = 2,
    parameter int unsigned BLKWORDS    = 2,
    parameter logic [31:0] HITCNT_ADDR = 32'h3100
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic [31:0] dmemload,
    output logic        dhit,
    output logic        flushed,
    output logic        memREN,
    output logic        memWEN,
    output logic [31:0] memaddr,
    output logic [31:0] memstore,
    input  logic [31:0] memload,
    input  logic        dwait
);

    localparam int unsigned WW      = (BLKWORDS > 1) ? $clog2(BLKWORDS) : 1;
    localparam int unsigned IW      = $clog2(NSETS);
    localparam int unsigned AW      = (NWAYS > 1) ? $clog2(NWAYS) : 1;
    localparam int unsigned IDX_LSB = 2 + $clog2(BLKWORDS);
    localparam int unsigned TAG_LSB = IDX_LSB + IW;
    localparam int unsigned TW      = 32 - TAG_LSB;

    typedef enum logic [2:0] {IDLE, WB, FILL, FLUSH, CNT_WR, DONE} state_t;

    state_t          state_q, state_d;
    logic [WW-1:0]   word_q, word_d;
    logic [AW-1:0]   victim_q, victim_d;
    logic [IW-1:0]   fset_q, fset_d;
    logic [AW-1:0]   fway_q, fway_d;
    logic [31:0]     hitcnt_q;

    logic            valid_q [NSETS][NWAYS];
    logic            dirty_q [NSETS][NWAYS];
    // Per-way age: 0 = MRU, larger = older; the oldest way is the LRU victim.
    logic [AW-1:0]   age_q   [NSETS][NWAYS];
    logic [TW-1:0]   tag_q   [NSETS][NWAYS];
    logic [31:0]     data_q  [NSETS][NWAYS][BLKWORDS];

    logic            req, is_wr;
    logic [IW-1:0]   req_idx;
    logic [TW-1:0]   req_tag;
    logic [WW-1:0]   req_word;
    logic            hit;
    logic [AW-1:0]   hit_way;
    logic [AW-1:0]   vic_sel;
    logic            vic_found;
    logic [AW-1:0]   best_age;
    logic            last_word, last_line;
    logic            wr_hit, fill_we, fill_done, wb_done, fl_wb_done, fl_adv;
    logic            unused_addr;

    assign unused_addr = ^dmemaddr[1:0];

    function automatic logic [31:0] blk_addr(input logic [TW-1:0] t, input logic [IW-1:0] i,
                                             input logic [WW-1:0] w);
        logic [31:0] a;
        a = 32'(t) << TAG_LSB;
        a = a | (32'(i) << IDX_LSB);
        a = a | (32'(w) << 2);
        return a;
    endfunction

    // Address decode. The datapath holds the request stable across a miss, so WB and
    // FILL keep using the live address for index and tag.
    assign req      = dmemREN | dmemWEN;
    assign is_wr    = dmemWEN;
    assign req_idx  = IW'(dmemaddr >> IDX_LSB);
    assign req_tag  = TW'(dmemaddr >> TAG_LSB);
    assign req_word = WW'((dmemaddr >> 2) & 32'(BLKWORDS - 1));

    assign last_word = (word_q == WW'(BLKWORDS - 1));
    assign last_line = (fset_q == IW'(NSETS - 1)) && (fway_q == AW'(NWAYS - 1));

    // Tag match.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NWAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = AW'(w);
            end
        end
    end

    // Victim: lowest invalid way, else the oldest way (lowest index on a tie).
    always_comb begin
        vic_sel   = '0;
        vic_found = 1'b0;
        best_age  = age_q[req_idx][0];
        for (int w = 0; w < NWAYS; w++) begin
            if (!valid_q[req_idx][w] && !vic_found) begin
                vic_sel   = AW'(w);
                vic_found = 1'b1;
            end
        end
        if (!vic_found) begin
            for (int w = 1; w < NWAYS; w++) begin
                if (age_q[req_idx][w] > best_age) begin
                    best_age = age_q[req_idx][w];
                    vic_sel  = AW'(w);
                end
            end
        end
    end

    // Next state and outputs.
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        victim_d   = victim_q;
        fset_d     = fset_q;
        fway_d     = fway_q;
        dhit       = 1'b0;
        dmemload   = '0;
        flushed    = 1'b0;
        memREN     = 1'b0;
        memWEN     = 1'b0;
        memaddr    = '0;
        memstore   = '0;
        wr_hit     = 1'b0;
        fill_we    = 1'b0;
        fill_done  = 1'b0;
        wb_done    = 1'b0;
        fl_wb_done = 1'b0;
        fl_adv     = 1'b0;

        case (state_q)
            IDLE: begin
                if (halt) begin
                    state_d = FLUSH;
                    fset_d  = '0;
                    fway_d  = '0;
                    word_d  = '0;
                end else if (req) begin
                    if (hit) begin
                        dhit     = 1'b1;
                        dmemload = data_q[req_idx][hit_way][req_word];
                        wr_hit   = is_wr;
                    end else begin
                        victim_d = vic_sel;
                        word_d   = '0;
                        state_d  = (valid_q[req_idx][vic_sel] && dirty_q[req_idx][vic_sel])
                                   ? WB : FILL;
                    end
                end
            end

            WB: begin
                memWEN   = 1'b1;
                memaddr  = blk_addr(tag_q[req_idx][victim_q], req_idx, word_q);
                memstore = data_q[req_idx][victim_q][word_q];
                if (!dwait) begin
                    if (last_word) begin
                        word_d  = '0;
                        wb_done = 1'b1;
                        state_d = FILL;
                    end else begin
                        word_d = word_q + 1'b1;
                    end
                end
            end

            FILL: begin
                memREN  = 1'b1;
                memaddr = blk_addr(req_tag, req_idx, word_q);
                if (!dwait) begin
                    fill_we = 1'b1;
                    if (last_word) begin
                        word_d    = '0;
                        fill_done = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        word_d = word_q + 1'b1;
                    end
                end
            end

            FLUSH: begin
                if (valid_q[fset_q][fway_q] && dirty_q[fset_q][fway_q]) begin
                    memWEN   = 1'b1;
                    memaddr  = blk_addr(tag_q[fset_q][fway_q], fset_q, word_q);
                    memstore = data_q[fset_q][fway_q][word_q];
                    if (!dwait) begin
                        if (last_word) begin
                            word_d     = '0;
                            fl_wb_done = 1'b1;
                            fl_adv     = 1'b1;
                        end else begin
                            word_d = word_q + 1'b1;
                        end
                    end
                end else begin
                    fl_adv = 1'b1;
                end
                if (fl_adv) begin
                    if (last_line) begin
                        state_d = CNT_WR;
                    end else if (fway_q == AW'(NWAYS - 1)) begin
                        fway_d = '0;
                        fset_d = fset_q + 1'b1;
                    end else begin
                        fway_d = fway_q + 1'b1;
                    end
                end
            end

            CNT_WR: begin
                memWEN   = 1'b1;
                memaddr  = HITCNT_ADDR;
                memstore = hitcnt_q;
                if (!dwait) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                flushed = 1'b1;
            end

            default: state_d = IDLE;
        endcase
    end

    // FSM state and counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            word_q   <= '0;
            victim_q <= '0;
            fset_q   <= '0;
            fway_q   <= '0;
            hitcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            victim_q <= victim_d;
            fset_q   <= fset_d;
            fway_q   <= fway_d;
            if (dhit) begin
                hitcnt_q <= hitcnt_q + 32'd1;
            end
        end
    end

    // Line metadata. Valid is only set once the last fill word lands, so a reset
    // mid-transfer can never leave a partial line valid.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int s = 0; s < NSETS; s++) begin
                for (int w = 0; w < NWAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= '0;
                end
            end
        end else begin
            if (dhit) begin
                // Hit way becomes MRU; ways no older than it age by one.
                for (int w = 0; w < NWAYS; w++) begin
                    if (AW'(w) == hit_way) begin
                        age_q[req_idx][w] <= '0;
                    end else if ((age_q[req_idx][w] <= age_q[req_idx][hit_way]) &&
                                 (age_q[req_idx][w] != AW'(NWAYS - 1))) begin
                        age_q[req_idx][w] <= age_q[req_idx][w] + 1'b1;
                    end
                end
            end
            if (wr_hit) begin
                dirty_q[req_idx][hit_way] <= 1'b1;
            end
            if (wb_done) begin
                dirty_q[req_idx][victim_q] <= 1'b0;
            end
            if (fill_done) begin
                valid_q[req_idx][victim_q] <= 1'b1;
                dirty_q[req_idx][victim_q] <= 1'b0;
            end
            if (fl_wb_done) begin
                dirty_q[fset_q][fway_q] <= 1'b0;
            end
        end
    end

    // Tag and data storage; contents are qualified by valid, so no reset needed.
    always_ff @(posedge CLK) begin
        if (wr_hit) begin
            data_q[req_idx][hit_way][req_word] <= dmemstore;
        end
        if (fill_we) begin
            data_q[req_idx][victim_q][word_q] <= memload;
        end
        if (fill_done) begin
            tag_q[req_idx][victim_q] <= req_tag;
        end
    end

endmodule

// File: tb/tb_assoc_dcache.sv
module tb_assoc_dcache;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        halt;
    logic        dmemREN, dmemWEN;
    logic [31:0] dmemaddr, dmemstore, dmemload;
    logic        dhit, flushed;
    logic        memREN, memWEN;
    logic [31:0] memaddr, memstore, memload;
    logic        dwait;

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_t;

    bus_t        bus_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] mem [0:4095];
    int          checks = 0;
    int          passes = 0;

    assoc_dcache #(
        .NSETS(8), .NWAYS(2), .BLKWORDS(2), .HITCNT_ADDR(32'h3100)
    ) dut (
        .CLK(CLK), .nRST(nRST), .halt(halt),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .dmemload(dmemload), .dhit(dhit), .flushed(flushed),
        .memREN(memREN), .memWEN(memWEN), .memaddr(memaddr), .memstore(memstore),
        .memload(memload), .dwait(dwait)
    );

    always #5 CLK = ~CLK;

    assign memload = mem[memaddr[13:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic exp_rd(input logic [31:0] a);
        bus_q.push_back('{wen: 1'b0, addr: a, data: 32'h0});
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
        bus_q.push_back('{wen: 1'b1, addr: a, data: d});
    endtask

    // Issue one request, hold it until dhit, and check the latency in cycles.
    task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_data, input int exp_cyc, input string name);
        int  cyc;
        bit  got;
        if (!wr) rd_q.push_back(exp_data);
        @(posedge CLK); #1;
        dmemREN   = !wr;
        dmemWEN   = wr;
        dmemaddr  = a;
        dmemstore = wd;
        cyc = 0;
        got = 0;
        while (!got && cyc < 200) begin
            @(negedge CLK);
            if (dhit) got = 1;
            else cyc++;
        end
        chk({name, " latency"}, 32'(cyc), 32'(exp_cyc));
        @(posedge CLK); #1;
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
    endtask

    // Read-data monitor.
    initial begin
        forever begin
            @(negedge CLK);
            if (nRST && dhit && dmemREN && !dmemWEN) begin
                if (rd_q.size() == 0) chk("unexpected read hit", 32'd1, 32'd0);
                else chk($sformatf("dmemload @%h", dmemaddr), dmemload, rd_q.pop_front());
            end
        end
    end

    // RAM transfer monitor.
    initial begin
        bus_t e;
        forever begin
            @(negedge CLK);
            if (nRST && (memREN || memWEN) && !dwait) begin
                if (bus_q.size() == 0) begin
                    chk($sformatf("unexpected xfer @%h", memaddr), 32'd1, 32'd0);
                end else begin
                    e = bus_q.pop_front();
                    chk("bus dir", {30'b0, memREN, memWEN}, {30'b0, !e.wen, e.wen});
                    chk("bus addr", memaddr, e.addr);
                    if (e.wen) chk($sformatf("bus wdata @%h", e.addr), memstore, e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h1000_0000 + 32'(i * 4);
        mem[32'h100 >> 2] = 32'hAAAA_0000;
        mem[32'h104 >> 2] = 32'hBBBB_0000;

        nRST = 1'b0; halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
        dmemaddr = '0; dmemstore = '0; dwait = 1'b0;
        #1;
        chk("reset dhit", {31'b0, dhit}, 32'd0);
        chk("reset flushed", {31'b0, flushed}, 32'd0);
        chk("reset memREN/WEN", {30'b0, memREN, memWEN}, 32'd0);
        chk("reset memaddr", memaddr, 32'd0);
        chk("reset memstore", memstore, 32'd0);
        chk("reset dmemload", dmemload, 32'd0);
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;

        // Cold read, then the other word of the block hits immediately.
        exp_rd(32'h100); exp_rd(32'h104);
        access(1'b0, 32'h100, 32'h0, 32'hAAAA_0000, 3, "cold read 0x100");
        access(1'b0, 32'h104, 32'h0, 32'hBBBB_0000, 0, "hit 0x104");

        // LRU: 0x180 must displace 0x140, not the more recently used 0x100.
        exp_rd(32'h140); exp_rd(32'h144);
        access(1'b0, 32'h140, 32'h0, 32'h1000_0140, 3, "miss 0x140");
        access(1'b0, 32'h100, 32'h0, 32'hAAAA_0000, 0, "hit 0x100");
        exp_rd(32'h180); exp_rd(32'h184);
        access(1'b0, 32'h180, 32'h0, 32'h1000_0180, 3, "miss 0x180");
        access(1'b0, 32'h100, 32'h0, 32'hAAAA_0000, 0, "rehit 0x100");
        exp_rd(32'h140); exp_rd(32'h144);
        access(1'b0, 32'h140, 32'h0, 32'h1000_0140, 3, "0x140 evicted");

        // Dirty eviction: 0x200 written, later displaced by 0x280.
        exp_rd(32'h200); exp_rd(32'h204);
        access(1'b1, 32'h200, 32'hDEAD_BEEF, 32'h0, 3, "write miss 0x200");
        exp_rd(32'h240); exp_rd(32'h244);
        access(1'b0, 32'h240, 32'h0, 32'h1000_0240, 3, "miss 0x240");
        exp_wr(32'h200, 32'hDEAD_BEEF); exp_wr(32'h204, 32'h1000_0204);
        exp_rd(32'h280); exp_rd(32'h284);
        access(1'b0, 32'h280, 32'h0, 32'h1000_0280, 5, "dirty evict 0x280");

        // Stall during FILL, then reset mid-FILL.
        @(posedge CLK); #1;
        dwait = 1'b1; dmemREN = 1'b1; dmemaddr = 32'h308;
        @(negedge CLK);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk($sformatf("stall cycle %0d", i), {dhit, memREN, memaddr[29:0]},
                {1'b0, 1'b1, 30'h308});
        end
        exp_rd(32'h308);
        @(posedge CLK); #1 dwait = 1'b0;
        @(posedge CLK); #1 dwait = 1'b1;
        @(negedge CLK);
        chk("fill word1 addr", memaddr, 32'h30C);
        #2 nRST = 1'b0;
        #1;
        chk("reset mid-fill memREN", {31'b0, memREN}, 32'd0);
        chk("reset mid-fill memaddr", memaddr, 32'd0);
        dmemREN = 1'b0; dwait = 1'b0;
        @(posedge CLK); #1 nRST = 1'b1;
        exp_rd(32'h308); exp_rd(32'h30C);
        access(1'b0, 32'h308, 32'h0, 32'h1000_0308, 3, "reread 0x308 misses");

        // Flush: two dirty lines, five hits since the reset.
        exp_rd(32'h400); exp_rd(32'h404);
        access(1'b1, 32'h400, 32'h1111_1111, 32'h0, 3, "write miss 0x400");
        exp_rd(32'h418); exp_rd(32'h41C);
        access(1'b1, 32'h418, 32'h2222_2222, 32'h0, 3, "write miss 0x418");
        access(1'b0, 32'h400, 32'h0, 32'h1111_1111, 0, "hit 0x400");
        access(1'b0, 32'h41C, 32'h0, 32'h1000_041C, 0, "hit 0x41C");
        exp_wr(32'h400, 32'h1111_1111); exp_wr(32'h404, 32'h1000_0404);
        exp_wr(32'h418, 32'h2222_2222); exp_wr(32'h41C, 32'h1000_041C);
        exp_wr(32'h3100, 32'd5);
        @(posedge CLK); #1 halt = 1'b1;
        n = 0;
        while (!flushed && n < 300) begin
            @(negedge CLK);
            n++;
        end
        chk("flushed reached", {31'b0, flushed}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("done hold", {29'b0, flushed, memREN, memWEN}, {29'b0, 1'b1, 1'b0, 1'b0});
        end
        chk("bus queue drained", 32'(bus_q.size()), 32'd0);
        chk("read queue drained", 32'(rd_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
